// File: rtl/vector_result_writeback.sv
`default_nettype none
// ============================================================================
// Module   : vector_result_writeback
// Purpose  : Writeback stage behind a fixed-latency vector functional unit.
//            Captures the FU result stream and writes one element per clock
//            into destination vector register Vi. It generates the element
//            address, the one-hot register write enable, a chaining count and
//            busy/done status.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            i_start    - issue pulse, samples i_i and i_vl
//            i_i        - destination vector register number
//            i_vl       - vector length (values above 64 clamp to 64)
//            i_result   - FU result stream, element k valid LATENCY+k clocks
//                         after the start edge
//            o_v_wr_en  - one-hot V register file write enable (bit i)
//            o_v_addr   - element address of the write
//            o_v_data   - element write data
//            o_elem_cnt - elements written so far (element k readable once
//                         o_elem_cnt > k)
//            o_busy     - high while an operation is in flight
//            o_done     - one-clock pulse after the final write / empty op
// Revision : 1.0 - initial release
// ============================================================================
module vector_result_writeback #(
    parameter int LATENCY = 4,
    parameter int DATA_W  = 64,
    parameter int VL_W    = 7,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [2:0]        i_i,
    input  logic [VL_W-1:0]   i_vl,
    input  logic [DATA_W-1:0] i_result,
    output logic [7:0]        o_v_wr_en,
    output logic [ADDR_W-1:0] o_v_addr,
    output logic [DATA_W-1:0] o_v_data,
    output logic [VL_W-1:0]   o_elem_cnt,
    output logic              o_busy,
    output logic              o_done
);

    localparam int c_WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int c_MAX_VL = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_i;
    logic [VL_W-1:0]     r_vl;
    logic [VL_W-1:0]     r_k;       // elements captured so far in this op
    logic [c_WAIT_W-1:0] r_wait;
    logic [VL_W-1:0]     w_vl_eff;
    logic                w_accept;
    logic                w_capture;

    assign w_vl_eff = (i_vl > VL_W'(c_MAX_VL)) ? VL_W'(c_MAX_VL) : i_vl;
    assign w_accept = (r_state == S_IDLE) && i_start;

    // Element 0 is captured on the edge that ends the last WAIT cycle, so the
    // write port shows it in the first WRITE cycle; the remaining elements
    // follow one per edge while still in WRITE.
    assign w_capture = ((r_state == S_WAIT) && (r_wait == '0) && (r_vl != '0)) ||
                       ((r_state == S_WRITE) && (r_k != r_vl));

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if ((LATENCY == 1) && (w_vl_eff == '0)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_wait == '0) begin
                    w_state_next = (r_vl != '0) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                // r_k reaching r_vl means the last element is on the port now.
                if (r_k == r_vl) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i        <= '0;
            r_vl       <= '0;
            r_k        <= '0;
            r_wait     <= '0;
            o_v_wr_en  <= '0;
            o_v_addr   <= '0;
            o_v_data   <= '0;
            o_elem_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_i    <= i_i;
                r_vl   <= w_vl_eff;
                r_k    <= '0;
                r_wait <= c_WAIT_W'(LATENCY - 1);
            end else if ((r_state == S_WAIT) && (r_wait != '0)) begin
                r_wait <= r_wait - 1'b1;
            end

            if (w_capture) begin
                o_v_data  <= i_result;
                o_v_addr  <= r_k[ADDR_W-1:0];
                o_v_wr_en <= 8'b1 << r_i;
                r_k       <= r_k + 1'b1;
            end else begin
                o_v_wr_en <= '0;
            end

            // A write counts as complete on the edge that ends its cycle.
            if (w_accept) begin
                o_elem_cnt <= '0;
            end else if (o_v_wr_en != '0) begin
                o_elem_cnt <= o_elem_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_result_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_result_writeback
// Purpose  : Directed self-checking bench for vector_result_writeback with a
//            scoreboard of expected register-file writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_result_writeback;

    localparam int c_LAT = 4;

    typedef struct {
        int          cyc;
        logic [7:0]  en;
        logic [5:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [2:0]  i_i;
    logic [6:0]  i_vl;
    logic [63:0] i_result;
    logic [7:0]  o_v_wr_en;
    logic [5:0]  o_v_addr;
    logic [63:0] o_v_data;
    logic [6:0]  o_elem_cnt;
    logic        o_busy;
    logic        o_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;      // rising edges seen so far
    logic [5:0]  last_addr = '0;
    logic [63:0] last_data = '0;
    wr_t         sb[$];

    vector_result_writeback #(
        .LATENCY (c_LAT),
        .DATA_W  (64),
        .VL_W    (7),
        .ADDR_W  (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_i        (i_i),
        .i_vl       (i_vl),
        .i_result   (i_result),
        .o_v_wr_en  (o_v_wr_en),
        .o_v_addr   (o_v_addr),
        .o_v_data   (o_v_data),
        .o_elem_cnt (o_elem_cnt),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value presented on i_result for the rising edge number n.
    function automatic logic [63:0] pat(input int n);
        return {32'hC0FE_0000 | 32'(n), 32'(n * 37 + 100)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, drive the next result word and compare
    // the write port against the scoreboard.
    task automatic tick();
        wr_t e;
        @(negedge clk);
        cyc++;
        i_result = pat(cyc + 1);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("wr_en", 64'(o_v_wr_en), 64'(e.en));
            check("addr", 64'(o_v_addr), 64'(e.addr));
            check("data", o_v_data, e.data);
            last_addr = e.addr;
            last_data = e.data;
        end else begin
            check("wr_en_idle", 64'(o_v_wr_en), 64'd0);
        end
    endtask

    task automatic push_op(input logic [2:0] i, input int vle, input int t);
        wr_t e;
        for (int k = 0; k < vle; k++) begin
            e.cyc  = t + c_LAT + k;
            e.en   = 8'b1 << i;
            e.addr = 6'(k);
            e.data = pat(t + c_LAT + k);
            sb.push_back(e);
        end
    endtask

    // Issue one op and check busy/done/elem_cnt every cycle until one cycle
    // after done. inj_a/inj_b: offsets from the start edge at which a second
    // (different) start is presented; 0 means none.
    task automatic run_op(input logic [2:0] i, input int vl, input int inj_a, input int inj_b);
        int t;
        int vle;
        int de;
        int c;
        vle = (vl > 64) ? 64 : vl;
        i_start = 1'b1;
        i_i     = i;
        i_vl    = 7'(vl);
        t       = cyc + 1;
        de      = t + c_LAT + vle;
        push_op(i, vle, t);
        tick();
        i_start = 1'b0;
        i_i     = ~i;
        i_vl    = 7'd3;
        for (int n = t; n <= de + 1; n++) begin
            c = cyc - (t + c_LAT);
            if (c < 0) c = 0;
            if (c > vle) c = vle;
            check("busy", 64'(o_busy), 64'((cyc >= t) && (cyc <= de)));
            check("done", 64'(o_done), 64'(cyc == de));
            check("elem_cnt", 64'(o_elem_cnt), 64'(c));
            if (n <= de) begin
                if ((cyc + 1 - t == inj_a) || (cyc + 1 - t == inj_b)) begin
                    i_start = 1'b1;
                    i_i     = i + 3'd1;
                    i_vl    = 7'd9;
                end else begin
                    i_start = 1'b0;
                end
                tick();
            end
        end
        i_start = 1'b0;
    endtask

    initial begin
        int t;
        rst      = 1'b1;
        i_start  = 1'b0;
        i_i      = '0;
        i_vl     = '0;
        i_result = pat(1);

        // Reset state
        tick();
        tick();
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_cnt", 64'(o_elem_cnt), 64'd0);
        check("rst_addr", 64'(o_v_addr), 64'd0);
        check("rst_data", o_v_data, 64'd0);
        rst = 1'b0;
        tick();

        // Basic op: i=3, vl=5; address/data hold afterwards
        run_op(3'd3, 5, 0, 0);
        check("hold_addr", 64'(o_v_addr), 64'(last_addr));
        check("hold_data", o_v_data, last_data);
        check("hold_addr4", 64'(last_addr), 64'd4);
        tick();

        // Empty op
        run_op(3'd4, 0, 0, 0);

        // Full length and clamped length
        run_op(3'd0, 64, 0, 0);
        run_op(3'd1, 100, 0, 0);

        // Starts while busy and in the DONE cycle are ignored
        run_op(3'd5, 6, 3, 8);
        run_op(3'd6, 2, c_LAT + 2 + 1, 0);
        run_op(3'd7, 3, 0, 0);

        // Asynchronous reset mid-write, after address 2 is on the port
        i_start = 1'b1;
        i_i     = 3'd2;
        i_vl    = 7'd10;
        t       = cyc + 1;
        push_op(3'd2, 10, t);
        tick();
        i_start = 1'b0;
        while (cyc < t + c_LAT + 2) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_wr_en", 64'(o_v_wr_en), 64'd0);
        check("arst_busy", 64'(o_busy), 64'd0);
        check("arst_done", 64'(o_done), 64'd0);
        check("arst_cnt", 64'(o_elem_cnt), 64'd0);
        check("arst_addr", 64'(o_v_addr), 64'd0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_op(3'd1, 3, 0, 0);

        // Chaining: per-cycle elem_cnt tracks completed writes
        run_op(3'd2, 8, 0, 0);
        tick();
        tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
